// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the FIFO pop arbiter.
package arb_pkg;
  localparam int unsigned N_FIFOS = 5;
  localparam int unsigned DATA_W  = 6;
  localparam int unsigned PTR_W   = 3;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_FIFOS-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [N_FIFOS-1:0] gnt_onehot,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               any
);
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int unsigned k = 0; k < N_FIFOS; k++) begin
      // Candidate index is (ptr + k) mod N_FIFOS; ptr never exceeds N_FIFOS-1.
      w_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N_FIFOS))
        w_sum = w_sum - (PTR_W+1)'(N_FIFOS);
      w_idx = w_sum[PTR_W-1:0];
      if (!any && req[w_idx]) begin
        any               = 1'b1;
        gnt_idx           = w_idx;
        gnt_onehot[w_idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_pop_arbiter.sv
// Round-robin drain of five FWFT input FIFOs into one output FIFO, with the
// RESET -> INIT -> IDLE <-> ACTIVE block FSM.
module fifo_pop_arbiter
  import arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      init,
  input  logic [N_FIFOS-1:0]        en_mask_in,
  input  logic [N_FIFOS-1:0]        fifo_empty,
  input  logic [N_FIFOS*DATA_W-1:0] fifo_data,
  input  logic                      out_almost_full,
  output logic [N_FIFOS-1:0]        fifo_pop,
  output logic                      out_push,
  output logic [DATA_W-1:0]         out_data,
  output logic                      idle,
  output logic [1:0]                state
);
  state_t              r_state, w_next;
  logic [PTR_W-1:0]    r_ptr, w_gnt_idx;
  logic [N_FIFOS-1:0]  r_en_mask, w_req, w_gnt;
  logic                w_any, w_pop_en;
  logic [DATA_W-1:0]   w_sel_data, r_out_data;
  logic                r_out_push, r_idle;

  assign w_req = ~fifo_empty & r_en_mask;

  rr_pick u_rr_pick (
    .req        (w_req),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // init pre-empts a pop in the same cycle it leaves ACTIVE.
  assign w_pop_en = (r_state == ST_ACTIVE) && !init && w_any && !out_almost_full;
  assign fifo_pop = w_pop_en ? w_gnt : '0;

  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < N_FIFOS; k++) begin
      if (w_gnt[k])
        w_sel_data = w_sel_data | fifo_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RESET:  w_next = ST_INIT;
      ST_INIT:   w_next = init ? ST_INIT : ST_IDLE;
      ST_IDLE:   w_next = init ? ST_INIT : (|w_req ? ST_ACTIVE : ST_IDLE);
      ST_ACTIVE: w_next = init ? ST_INIT : (|w_req ? ST_ACTIVE : ST_IDLE);
      default:   w_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_RESET;
      r_ptr      <= '0;
      r_en_mask  <= '1;
      r_out_push <= 1'b0;
      r_out_data <= '0;
      r_idle     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_idle     <= (w_next == ST_IDLE);
      r_out_push <= w_pop_en;
      if (r_state == ST_INIT && !init)
        r_en_mask <= en_mask_in;
      if (w_pop_en) begin
        r_out_data <= w_sel_data;
        r_ptr      <= (w_gnt_idx == PTR_W'(N_FIFOS-1)) ? '0 : w_gnt_idx + PTR_W'(1);
      end
    end
  end

  assign out_push = r_out_push;
  assign out_data = r_out_data;
  assign idle     = r_idle;
  assign state    = r_state;
endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Directed bench for fifo_pop_arbiter; input FIFOs are modelled as word counters.
module tb_fifo_pop_arbiter;
  logic        clk = 1'b0;
  logic        reset_L;
  logic        init;
  logic [4:0]  en_mask_in;
  logic [4:0]  fifo_empty;
  logic [29:0] fifo_data;
  logic        out_almost_full;
  logic [4:0]  fifo_pop;
  logic        out_push;
  logic [5:0]  out_data;
  logic        idle;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt[5];
  int pops[5];

  fifo_pop_arbiter dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .init            (init),
    .en_mask_in      (en_mask_in),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .out_almost_full (out_almost_full),
    .fifo_pop        (fifo_pop),
    .out_push        (out_push),
    .out_data        (out_data),
    .idle            (idle),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < 5; i++) begin
      fifo_empty[i] = (cnt[i] == 0);
      fifo_data[i*6 +: 6] = 6'(8'h0A + i);
    end
  endtask

  // Starts and ends just after a falling edge; pops seen before the rising
  // edge consume one word from the modelled FIFO.
  task automatic tick();
    logic [4:0] p;
    #1;
    p = fifo_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (p[i] && cnt[i] > 0) begin
        cnt[i]--;
        pops[i]++;
      end
    end
    drive_fifos();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0; init = 1'b1; en_mask_in = 5'b11111; out_almost_full = 1'b0;
    for (int i = 0; i < 5; i++) begin cnt[i] = 0; pops[i] = 0; end
    drive_fifos();

    // 1: reset and init sequencing
    @(negedge clk); @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_idle", 32'(idle), 32'd0);
    check_eq("rst_push", 32'(out_push), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_pop", 32'(fifo_pop), 32'd0);
    reset_L = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("init_state", 32'(state), 32'd1);
      check_eq("init_idle", 32'(idle), 32'd0);
    end
    init = 1'b0;
    tick();
    check_eq("t1_state", 32'(state), 32'd2);
    check_eq("t1_idle", 32'(idle), 32'd1);
    check_eq("t1_pop", 32'(fifo_pop), 32'd0);

    // 2: FIFOs 0,2,4 hold one word each
    cnt[0] = 1; cnt[2] = 1; cnt[4] = 1;
    drive_fifos();
    tick();
    check_eq("t2_state", 32'(state), 32'd3);
    check_eq("t2_pop0", 32'(fifo_pop), 32'b00001);
    check_eq("t2_push0", 32'(out_push), 32'd0);
    tick();
    check_eq("t2_pop1", 32'(fifo_pop), 32'b00100);
    check_eq("t2_push1", 32'(out_push), 32'd1);
    check_eq("t2_data1", 32'(out_data), 32'h0A);
    tick();
    check_eq("t2_pop2", 32'(fifo_pop), 32'b10000);
    check_eq("t2_data2", 32'(out_data), 32'h0C);
    tick();
    check_eq("t2_pop3", 32'(fifo_pop), 32'd0);
    check_eq("t2_push3", 32'(out_push), 32'd1);
    check_eq("t2_data3", 32'(out_data), 32'h0E);
    tick();
    check_eq("t2_idle_state", 32'(state), 32'd2);
    check_eq("t2_idle", 32'(idle), 32'd1);
    check_eq("t2_push4", 32'(out_push), 32'd0);
    check_eq("t2_hold", 32'(out_data), 32'h0E);

    // 3: two words in every FIFO, full rotation twice with wrap
    for (int i = 0; i < 5; i++) begin cnt[i] = 2; pops[i] = 0; end
    drive_fifos();
    tick();
    for (int k = 0; k < 10; k++) begin
      check_eq("t3_pop", 32'(fifo_pop), 32'(1 << (k % 5)));
      if (k > 0) begin
        check_eq("t3_push", 32'(out_push), 32'd1);
        check_eq("t3_data", 32'(out_data), 32'(8'h0A + ((k - 1) % 5)));
      end
      tick();
    end
    check_eq("t3_pop_end", 32'(fifo_pop), 32'd0);
    check_eq("t3_data_end", 32'(out_data), 32'h0E);
    tick();
    check_eq("t3_idle", 32'(idle), 32'd1);
    for (int i = 0; i < 5; i++) check_eq("t3_popcount", 32'(pops[i]), 32'd2);

    // 4: output stall with FIFO 1 pending
    out_almost_full = 1'b1;
    cnt[1] = 1;
    drive_fifos();
    tick();
    for (int j = 0; j < 4; j++) begin
      check_eq("t4_stall_state", 32'(state), 32'd3);
      check_eq("t4_stall_pop", 32'(fifo_pop), 32'd0);
      check_eq("t4_stall_push", 32'(out_push), 32'd0);
      tick();
    end
    out_almost_full = 1'b0;
    #1;
    check_eq("t4_release_pop", 32'(fifo_pop), 32'b00010);
    tick();
    check_eq("t4_push", 32'(out_push), 32'd1);
    check_eq("t4_data", 32'(out_data), 32'h0B);
    tick();
    check_eq("t4_idle_state", 32'(state), 32'd2);

    // 5: masked FIFO must not wake IDLE
    init = 1'b1;
    tick();
    check_eq("t5_init_state", 32'(state), 32'd1);
    check_eq("t5_init_idle", 32'(idle), 32'd0);
    en_mask_in = 5'b11101;
    init = 1'b0;
    tick();
    check_eq("t5_idle_state", 32'(state), 32'd2);
    cnt[1] = 1;
    drive_fifos();
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq("t5_state", 32'(state), 32'd2);
      check_eq("t5_idle", 32'(idle), 32'd1);
      check_eq("t5_pop1", 32'(fifo_pop[1]), 32'd0);
    end
    cnt[1] = 0;
    drive_fifos();
    en_mask_in = 5'b11111;
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    check_eq("t5_back_idle", 32'(state), 32'd2);

    // 6: reset between a pop and its push (ptr is 2 here)
    cnt[3] = 2;
    drive_fifos();
    tick();
    check_eq("t6_pop_a", 32'(fifo_pop), 32'b01000);
    tick();
    check_eq("t6_push_a", 32'(out_push), 32'd1);
    check_eq("t6_pop_b", 32'(fifo_pop), 32'b01000);
    #2;
    reset_L = 1'b0;
    #1;
    check_eq("t6_rst_push", 32'(out_push), 32'd0);
    check_eq("t6_rst_idle", 32'(idle), 32'd0);
    check_eq("t6_rst_state", 32'(state), 32'd0);
    check_eq("t6_rst_pop", 32'(fifo_pop), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t6_hold_push", 32'(out_push), 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    check_eq("t6_post_state", 32'(state), 32'd1);
    check_eq("t6_post_push", 32'(out_push), 32'd0);
    tick();
    check_eq("t6_post_idle", 32'(idle), 32'd1);
    check_eq("t6_post_push2", 32'(out_push), 32'd0);
    tick();
    check_eq("t6_resume_pop", 32'(fifo_pop), 32'b01000);
    tick();
    check_eq("t6_resume_push", 32'(out_push), 32'd1);
    check_eq("t6_resume_data", 32'(out_data), 32'h0D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
